// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port unified memory between instruction
// fetch and the load/store data port. One transaction in flight at a time,
// fixed read latency MEM_LAT (1..15).
// Optional feature macro: ARB_RR_EN. When it is defined, conflicts are settled
// round-robin. When it is undefined, data has priority and a starvation guard
// applies.
module mem_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4,
  parameter int AW         = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [31:0]   if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_valid,
  output logic [31:0]   d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic [1:0]    arb_state,
  output logic          last_owner
);

  typedef enum logic [1:0] {IDLE = 2'b00, ISSUE = 2'b01, WAIT = 2'b10, RESP = 2'b11} state_t;

  state_t          state_q;
  logic [3:0]      lat_q, lat_d;
  logic            txn_we_q;      // current transaction is a store
  logic            owner_q;       // 0=fetch, 1=data; also the current winner
  logic            if_gnt_q, d_gnt_q, if_valid_q, d_valid_q;
  logic            mem_en_q, mem_we_q;
  logic [AW-1:0]   mem_addr_q;
  logic [31:0]     mem_wdata_q, if_rdata_q, d_rdata_q;
  logic            data_win_d;
`ifndef ARB_RR_EN
  logic [3:0]      starve_q, starve_d;
`endif

  // Pick the winner for a grant made from IDLE and the next latency count.
  always_comb begin
    data_win_d = 1'b0;
    lat_d      = lat_q - 4'd1;
`ifdef ARB_RR_EN
    // On conflict the port that did not own the last grant wins.
    data_win_d = d_req && (!if_req || !owner_q);
`else
    starve_d   = '0;
    data_win_d = d_req && (!if_req || starve_q != 4'(STARVE_MAX));
    // Count data grants that overtook a waiting fetch; anything else clears.
    if (if_req && data_win_d)
      starve_d = (starve_q == 4'(STARVE_MAX)) ? starve_q : starve_q + 4'd1;
`endif
  end

  // Arbitration FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      txn_we_q    <= 1'b0;
      owner_q     <= 1'b0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
`ifndef ARB_RR_EN
      starve_q    <= '0;
`endif
    end else begin
      // Pulses default low and are raised only for the cycle that needs them.
      if_gnt_q   <= 1'b0;
      d_gnt_q    <= 1'b0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      case (state_q)
        IDLE: begin
`ifndef ARB_RR_EN
          starve_q <= starve_d;
`endif
          if (if_req || d_req) begin
            state_q     <= ISSUE;
            owner_q     <= data_win_d;
            if_gnt_q    <= !data_win_d;
            d_gnt_q     <= data_win_d;
            mem_en_q    <= 1'b1;
            mem_we_q    <= data_win_d && d_we;
            txn_we_q    <= data_win_d && d_we;
            mem_addr_q  <= data_win_d ? d_addr : if_addr;
            mem_wdata_q <= data_win_d ? d_wdata : '0;
          end
        end
        ISSUE: begin
          if (MEM_LAT == 1) begin
            state_q <= RESP;
            if (owner_q) begin
              d_valid_q <= 1'b1;
              if (!txn_we_q) d_rdata_q <= mem_rdata;
            end else begin
              if_valid_q <= 1'b1;
              if_rdata_q <= mem_rdata;
            end
          end else begin
            state_q <= WAIT;
            lat_q   <= 4'(MEM_LAT - 1);
          end
        end
        WAIT: begin
          // Leave when the count reaches zero so valid lands MEM_LAT cycles after gnt.
          lat_q <= lat_d;
          if (lat_d == 4'd0) begin
            state_q <= RESP;
            if (owner_q) begin
              d_valid_q <= 1'b1;
              if (!txn_we_q) d_rdata_q <= mem_rdata;
            end else begin
              if_valid_q <= 1'b1;
              if_rdata_q <= mem_rdata;
            end
          end
        end
        default: state_q <= IDLE;  // RESP: valid is showing this cycle
      endcase
    end
  end

  assign if_gnt     = if_gnt_q;
  assign d_gnt      = d_gnt_q;
  assign if_valid   = if_valid_q;
  assign d_valid    = d_valid_q;
  assign if_rdata   = if_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign arb_state  = state_q;
  assign last_owner = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a MEM_LAT=2 instance carrying the main
// scenarios and a MEM_LAT=1 instance exercising the short-latency path.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we, last_owner;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  arb_state;
  // MEM_LAT=1 instance, fetch only
  logic        if_req1, d_req1, d_we1;
  logic [31:0] if_addr1, d_addr1, d_wdata1;
  logic        if_gnt1, if_valid1, d_gnt1, d_valid1, mem_en1, mem_we1, last_owner1;
  logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic [1:0]  arb_state1;

  logic [31:0] mem [0:255];
  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  // Word memory: writes on a strobed store, reads follow the held address.
  always @(posedge clk) if (mem_en && mem_we) mem[mem_addr[9:2]] = mem_wdata;
  assign mem_rdata  = mem[mem_addr[9:2]];
  assign mem_rdata1 = mem[mem_addr1[9:2]];

  mem_arbiter #(.MEM_LAT(2), .STARVE_MAX(4), .AW(32)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .arb_state(arb_state), .last_owner(last_owner));

  mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(4), .AW(32)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1), .if_valid(if_valid1), .if_rdata(if_rdata1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_gnt(d_gnt1), .d_valid(d_valid1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .arb_state(arb_state1), .last_owner(last_owner1));

  task automatic do_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset;
    if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
    if_req1 = 0; d_req1 = 0; d_we1 = 0; if_addr1 = 0; d_addr1 = 0; d_wdata1 = 0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_tot++; if (arb_state !== 2'b00) $display("FAIL reset_state: got %b want 00", arb_state); else n_pass++;
    n_tot++; if ({if_gnt, d_gnt, if_valid, d_valid, mem_en, mem_we} !== 6'b0)
      $display("FAIL reset_strobes: got %b want 000000", {if_gnt, d_gnt, if_valid, d_valid, mem_en, mem_we}); else n_pass++;
    n_tot++; if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'b0)
      $display("FAIL reset_regs: got %h want 0", {mem_addr, mem_wdata, if_rdata, d_rdata}); else n_pass++;
    n_tot++; if (last_owner !== 1'b0) $display("FAIL reset_owner: got %b want 0", last_owner); else n_pass++;
    rst = 1'b1;
  endtask

  task automatic test_fetch_alone;
    @(negedge clk); if_req = 1; if_addr = 32'h10;
    @(negedge clk);
    n_tot++; if ({if_gnt, d_gnt, mem_en, mem_we} !== 4'b1010)
      $display("FAIL fetch_issue: got gnt/dgnt/en/we %b want 1010", {if_gnt, d_gnt, mem_en, mem_we}); else n_pass++;
    n_tot++; if (mem_addr !== 32'h10) $display("FAIL fetch_addr: got %h want 00000010", mem_addr); else n_pass++;
    n_tot++; if (arb_state !== 2'b01) $display("FAIL fetch_st_issue: got %b want 01", arb_state); else n_pass++;
    if_req = 0;
    @(negedge clk);
    n_tot++; if (arb_state !== 2'b10 || if_valid !== 1'b0 || mem_en !== 1'b0)
      $display("FAIL fetch_wait: got st %b valid %b en %b want 10 0 0", arb_state, if_valid, mem_en); else n_pass++;
    @(negedge clk);
    n_tot++; if (if_valid !== 1'b1 || if_rdata !== 32'h00500093)
      $display("FAIL fetch_valid: got %b %h want 1 00500093", if_valid, if_rdata); else n_pass++;
    n_tot++; if (arb_state !== 2'b11) $display("FAIL fetch_st_resp: got %b want 11", arb_state); else n_pass++;
    @(negedge clk);
    n_tot++; if (arb_state !== 2'b00 || if_valid !== 1'b0)
      $display("FAIL fetch_idle: got st %b valid %b want 00 0", arb_state, if_valid); else n_pass++;
  endtask

  task automatic test_store_load;
    @(negedge clk); d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    n_tot++; if ({d_gnt, if_gnt, mem_en, mem_we} !== 4'b1011)
      $display("FAIL store_issue: got dgnt/igt/en/we %b want 1011", {d_gnt, if_gnt, mem_en, mem_we}); else n_pass++;
    n_tot++; if (mem_addr !== 32'h40 || mem_wdata !== 32'hDEADBEEF)
      $display("FAIL store_bus: got %h %h want 00000040 deadbeef", mem_addr, mem_wdata); else n_pass++;
    d_req = 0; d_we = 0;
    @(negedge clk);
    n_tot++; if (mem_we !== 1'b0 || mem_en !== 1'b0)
      $display("FAIL store_we_once: got we %b en %b want 0 0", mem_we, mem_en); else n_pass++;
    @(negedge clk);
    n_tot++; if (d_valid !== 1'b1 || d_rdata !== 32'h0)
      $display("FAIL store_resp: got valid %b rdata %h want 1 00000000", d_valid, d_rdata); else n_pass++;
    n_tot++; if (last_owner !== 1'b1 || if_rdata !== 32'h00500093)
      $display("FAIL store_owner: got owner %b if_rdata %h want 1 00500093", last_owner, if_rdata); else n_pass++;
    @(negedge clk); d_req = 1; d_we = 0; d_addr = 32'h40;
    @(negedge clk);
    n_tot++; if (d_gnt !== 1'b1 || mem_we !== 1'b0)
      $display("FAIL load_issue: got gnt %b we %b want 1 0", d_gnt, mem_we); else n_pass++;
    d_req = 0;
    repeat (2) @(negedge clk);
    n_tot++; if (d_valid !== 1'b1 || d_rdata !== 32'hDEADBEEF)
      $display("FAIL load_data: got %b %h want 1 deadbeef", d_valid, d_rdata); else n_pass++;
    n_tot++; if (if_rdata !== 32'h00500093)
      $display("FAIL load_if_untouched: got %h want 00500093", if_rdata); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_conflict;
    bit expd [10];
    int g = 0;
    int last = 0;
`ifdef ARB_RR_EN
    expd = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
`else
    expd = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
`endif
    do_reset();
    if_req = 1; if_addr = 32'h10; d_req = 1; d_we = 0; d_addr = 32'h40;
    for (int cyc = 0; cyc < 200 && g < 10; cyc++) begin
      @(negedge clk);
      if (if_gnt || d_gnt) begin
        n_tot++;
        if ({d_gnt, if_gnt, last_owner} !== {expd[g], !expd[g], expd[g]})
          $display("FAIL conflict_order[%0d]: got dgnt/igt/owner %b want %b", g,
                   {d_gnt, if_gnt, last_owner}, {expd[g], !expd[g], expd[g]});
        else n_pass++;
        if (g > 0) begin
          n_tot++; if (cyc - last !== 4) $display("FAIL conflict_spacing[%0d]: got %0d want 4", g, cyc - last); else n_pass++;
        end
        last = cyc;
        g++;
      end
    end
    n_tot++; if (g !== 10) $display("FAIL conflict_timeout: got %0d grants want 10", g); else n_pass++;
    if_req = 0; d_req = 0;
    repeat (5) @(negedge clk);
    n_tot++; if (arb_state !== 2'b00) $display("FAIL conflict_drain: got %b want 00", arb_state); else n_pass++;
  endtask

  task automatic test_reset_mid_wait;
    int seen = 0;
    d_req = 1; d_we = 0; d_addr = 32'h40;
    @(negedge clk);
    n_tot++; if (d_gnt !== 1'b1) $display("FAIL rstmid_gnt: got %b want 1", d_gnt); else n_pass++;
    d_req = 0;
    @(negedge clk);
    n_tot++; if (arb_state !== 2'b10) $display("FAIL rstmid_wait: got %b want 10", arb_state); else n_pass++;
    rst = 0;
    @(negedge clk);
    n_tot++; if ({d_valid, mem_en, arb_state} !== 4'b0000)
      $display("FAIL rstmid_abort: got valid/en/st %b want 0000", {d_valid, mem_en, arb_state}); else n_pass++;
    n_tot++; if (d_rdata !== 32'h0) $display("FAIL rstmid_rdata: got %h want 00000000", d_rdata); else n_pass++;
    rst = 1;
    repeat (3) begin @(negedge clk); if (d_valid) seen++; end
    n_tot++; if (seen !== 0) $display("FAIL rstmid_no_valid: got %0d pulses want 0", seen); else n_pass++;
    if_req = 1; if_addr = 32'h10;
    @(negedge clk);
    n_tot++; if (if_gnt !== 1'b1) $display("FAIL rstmid_fetch_gnt: got %b want 1", if_gnt); else n_pass++;
    if_req = 0;
    repeat (2) @(negedge clk);
    n_tot++; if (if_valid !== 1'b1 || if_rdata !== 32'h00500093)
      $display("FAIL rstmid_fetch: got %b %h want 1 00500093", if_valid, if_rdata); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_lat1;
    if_req1 = 1; if_addr1 = 32'h10;
    @(negedge clk);
    n_tot++; if (if_gnt1 !== 1'b1 || arb_state1 !== 2'b01)
      $display("FAIL lat1_issue: got gnt %b st %b want 1 01", if_gnt1, arb_state1); else n_pass++;
    if_req1 = 0;
    @(negedge clk);
    n_tot++; if (arb_state1 !== 2'b11 || if_valid1 !== 1'b1 || if_rdata1 !== 32'h00500093)
      $display("FAIL lat1_resp: got st %b valid %b rdata %h want 11 1 00500093", arb_state1, if_valid1, if_rdata1); else n_pass++;
    @(negedge clk);
    n_tot++; if (arb_state1 !== 2'b00 || if_valid1 !== 1'b0)
      $display("FAIL lat1_idle: got st %b valid %b want 00 0", arb_state1, if_valid1); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[4] = 32'h00500093;
    test_reset();
    test_fetch_alone();
    test_store_load();
    test_conflict();
    test_reset_mid_wait();
    test_lat1();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
